regfile_wb_sched: RTL and testbench

- Write-back scheduler and hazard scoreboard in front of the 32x64 register file.
- Shares the regfile's single write port among NREQ write-back sources (ALU, MUL/DIV, LSU) using round-robin arbitration, and drives the regfile write-enable, address and data from a registered stage.
- Keeps a per-register busy scoreboard so the decode stage can stall on RAW/WAW hazards against in-flight writes.
- Sits between the execute/memory units and the write-back regfile.

---
 rtl/regfile_wb_sched.sv | 108 ++++++++++
 tb/tb_regfile_wb_sched.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin shares the single regfile write port among
// NREQ sources and keeps a per-register busy scoreboard for decode hazard stalls.
module regfile_wb_sched #(
    parameter int NREQ = 3,
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rdaddr,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rdaddr,
    input  logic                 iss_rd_en,
    input  logic [AW-1:0]        rs1addr,
    input  logic [AW-1:0]        rs2addr,
    output logic                 iss_stall,
    output logic                 RFwe,
    output logic [AW-1:0]        rf_rdaddr,
    output logic [XLEN-1:0]      rf_rd,
    output logic [1:0]           grant_id,
    output logic                 wb_finish
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_found;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    logic            rfwe_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] data_q;
    logic [1:0]      grant_q;
    logic            finish_q;

    logic [NREG-1:0] busy_q, busy_d;
    logic            iss_set;

    // Round-robin search starting at rr_ptr_q; first valid source wins.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
        if (gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign sel_addr = req_rdaddr[int'(gnt_idx)*AW +: AW];
    assign sel_data = req_data[int'(gnt_idx)*XLEN +: XLEN];
    assign rr_ptr_d = gnt_found ? PW'((int'(gnt_idx) + 1) % NREQ) : rr_ptr_q;

    assign iss_stall = iss_valid && (busy_q[rs1addr] || busy_q[rs2addr] ||
                                     (iss_rd_en && busy_q[iss_rdaddr]));
    assign iss_set   = iss_valid && iss_rd_en && !iss_stall && (iss_rdaddr != '0);

    // Set is applied after clear so a new producer keeps ownership on a collision.
    always_comb begin
        busy_d = busy_q;
        if (gnt_found) busy_d[sel_addr] = 1'b0;
        if (iss_set)   busy_d[iss_rdaddr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the busy array is plain flops, not a RAM, so it is reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            rfwe_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            grant_q  <= '0;
            finish_q <= 1'b0;
            busy_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            finish_q <= rfwe_q;
            busy_q   <= busy_d;
            if (gnt_found) begin
                rfwe_q  <= (sel_addr != '0);
                addr_q  <= sel_addr;
                data_q  <= sel_data;
                grant_q <= 2'(gnt_idx);
            end else begin
                rfwe_q  <= 1'b0;
            end
        end
    end

    assign RFwe      = rfwe_q;
    assign rf_rdaddr = addr_q;
    assign rf_rd     = data_q;
    assign grant_id  = grant_q;
    assign wb_finish = finish_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: expected write-backs queued at handshake time,
// popped by a monitor after each rising edge; hazard/arbiter checks inline.
module tb_regfile_wb_sched;

    localparam int NREQ = 3;
    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_rdaddr;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rdaddr;
    logic                 iss_rd_en;
    logic [AW-1:0]        rs1addr;
    logic [AW-1:0]        rs2addr;
    logic                 iss_stall;
    logic                 RFwe;
    logic [AW-1:0]        rf_rdaddr;
    logic [XLEN-1:0]      rf_rd;
    logic [1:0]           grant_id;
    logic                 wb_finish;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [1:0]      id;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  prev_we = 1'b0;

    regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rdaddr (req_rdaddr),
        .req_data   (req_data),
        .iss_valid  (iss_valid),
        .iss_rdaddr (iss_rdaddr),
        .iss_rd_en  (iss_rd_en),
        .rs1addr    (rs1addr),
        .rs2addr    (rs2addr),
        .iss_stall  (iss_stall),
        .RFwe       (RFwe),
        .rf_rdaddr  (rf_rdaddr),
        .rf_rd      (rf_rd),
        .grant_id   (grant_id),
        .wb_finish  (wb_finish)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Registered outputs sampled 2 time units after each rising edge.
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!mon_en) begin
                prev_we = 1'b0;
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (RFwe !== e.we) begin
                        errors++;
                        $display("FAIL wb_we: RFwe=%b expected %b at %0t", RFwe, e.we, $time);
                    end
                    checks++;
                    if (rf_rdaddr !== e.addr) begin
                        errors++;
                        $display("FAIL wb_addr: rf_rdaddr=%0d expected %0d at %0t", rf_rdaddr, e.addr, $time);
                    end
                    checks++;
                    if (rf_rd !== e.data) begin
                        errors++;
                        $display("FAIL wb_data: rf_rd=%h expected %h at %0t", rf_rd, e.data, $time);
                    end
                    checks++;
                    if (grant_id !== e.id) begin
                        errors++;
                        $display("FAIL wb_grant_id: grant_id=%0d expected %0d at %0t", grant_id, e.id, $time);
                    end
                end else begin
                    e.we = 1'b0;
                    checks++;
                    if (RFwe !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_we: RFwe=%b expected 0 at %0t", RFwe, $time);
                    end
                end
                checks++;
                if (wb_finish !== prev_we) begin
                    errors++;
                    $display("FAIL wb_finish: wb_finish=%b expected %b at %0t", wb_finish, prev_we, $time);
                end
                prev_we = e.we;
            end
        end
    end

    task automatic drive_idle();
        req_valid  = '0;
        iss_valid  = 1'b0;
        iss_rd_en  = 1'b0;
        iss_rdaddr = '0;
        rs1addr    = '0;
        rs2addr    = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        req_rdaddr[i*AW +: AW]     = a;
        req_data[i*XLEN +: XLEN]   = d;
        req_valid[i]               = 1'b1;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        req_rdaddr = '0;
        req_data   = '0;
        #1;
        checks++;
        if ({RFwe, wb_finish} !== 2'b00) begin
            errors++;
            $display("FAIL reset_we_finish: RFwe=%b wb_finish=%b expected 0 0", RFwe, wb_finish);
        end
        checks++;
        if (rf_rdaddr !== '0 || rf_rd !== '0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: addr=%0d data=%h id=%0d expected all 0", rf_rdaddr, rf_rd, grant_id);
        end
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b expected 000", req_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        apply_reset();
        @(negedge clk);
        set_req(0, 5'd5, 64'h0000_0000_DEAD_BEEF);
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL single_ready: req_ready=%b expected 001", req_ready);
        end
        exp_q.push_back('{we: 1'b1, addr: 5'd5, data: 64'h0000_0000_DEAD_BEEF, id: 2'd0});
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL single_ready_drop: req_ready=%b expected 000", req_ready);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int seq_all[6] = '{0, 1, 2, 0, 1, 2};
        int g;
        logic [XLEN-1:0] d[NREQ];
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = '0;
            for (int i = 0; i < NREQ; i++) d[i] = {$urandom, $urandom};
            if (k < 6) begin
                for (int i = 0; i < NREQ; i++) set_req(i, 5'(8 + i), d[i]);
                g = seq_all[k];
            end else begin
                set_req(0, 5'd8, d[0]);
                set_req(2, 5'd10, d[2]);
                g = (k % 2 == 0) ? 0 : 2;
            end
            #1;
            checks++;
            if (req_ready !== 3'(1 << g)) begin
                errors++;
                $display("FAIL rr_order[%0d]: req_ready=%b expected %b", k, req_ready, 3'(1 << g));
            end
            exp_q.push_back('{we: 1'b1, addr: 5'(8 + g), data: d[g], id: 2'(g)});
        end
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_raw_stall();
        apply_reset();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rdaddr = 5'd7;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_first_issue: iss_stall=%b expected 0", iss_stall);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            iss_valid = 1'b1; iss_rd_en = 1'b0; iss_rdaddr = 5'd0; rs1addr = 5'd7;
            if (c == 2) set_req(2, 5'd7, 64'h5555_AAAA_0000_0007);
            #1;
            checks++;
            if (iss_stall !== 1'b1) begin
                errors++;
                $display("FAIL raw_stall[%0d]: iss_stall=%b expected 1", c, iss_stall);
            end
        end
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL raw_lsu_ready: req_ready=%b expected 100", req_ready);
        end
        exp_q.push_back('{we: 1'b1, addr: 5'd7, data: 64'h5555_AAAA_0000_0007, id: 2'd2});
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_release: iss_stall=%b expected 0", iss_stall);
        end
        drive_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_collision();
        apply_reset();
        @(negedge clk);
        set_req(0, 5'd9, 64'h0909_0909_0909_0909);
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rdaddr = 5'd9;
        #1;
        checks++;
        if (iss_stall !== 1'b0 || req_ready !== 3'b001) begin
            errors++;
            $display("FAIL collide_setup: iss_stall=%b req_ready=%b expected 0 001", iss_stall, req_ready);
        end
        exp_q.push_back('{we: 1'b1, addr: 5'd9, data: 64'h0909_0909_0909_0909, id: 2'd0});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_idle();
            iss_valid = 1'b1; rs2addr = 5'd9;
            #1;
            checks++;
            if (iss_stall !== 1'b1) begin
                errors++;
                $display("FAIL collide_rs2_stall[%0d]: iss_stall=%b expected 1", c, iss_stall);
            end
        end
        @(negedge clk);
        drive_idle();
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rdaddr = 5'd9;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL collide_waw_stall: iss_stall=%b expected 1", iss_stall);
        end
        drive_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_x0();
        apply_reset();
        @(negedge clk);
        set_req(1, 5'd0, 64'h0BAD_F00D_CAFE_0001);
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL x0_ready: req_ready=%b expected 010", req_ready);
        end
        exp_q.push_back('{we: 1'b0, addr: 5'd0, data: 64'h0BAD_F00D_CAFE_0001, id: 2'd1});
        @(negedge clk);
        drive_idle();
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rdaddr = 5'd0;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_issue: iss_stall=%b expected 0", iss_stall);
        end
        @(negedge clk);
        rs1addr = 5'd0; rs2addr = 5'd0;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_rs1: iss_stall=%b expected 0", iss_stall);
        end
        drive_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int r = 4; r < 8; r++) begin
            @(negedge clk);
            drive_idle();
            iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rdaddr = 5'(r);
            if (r == 7) begin
                set_req(0, 5'd3, 64'h1234_5678_9ABC_DEF0);
                exp_q.push_back('{we: 1'b1, addr: 5'd3, data: 64'h1234_5678_9ABC_DEF0, id: 2'd0});
            end
            #1;
            checks++;
            if (iss_stall !== 1'b0) begin
                errors++;
                $display("FAIL arst_fill[%0d]: iss_stall=%b expected 0", r, iss_stall);
            end
        end
        @(negedge clk);
        drive_idle();
        iss_valid = 1'b1; rs1addr = 5'd4; rs2addr = 5'd7;
        #1;
        checks++;
        if (iss_stall !== 1'b1 || RFwe !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: iss_stall=%b RFwe=%b expected 1 1", iss_stall, RFwe);
        end
        #1;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({RFwe, wb_finish} !== 2'b00 || rf_rdaddr !== '0 || rf_rd !== '0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL arst_outputs: RFwe=%b fin=%b addr=%0d data=%h id=%0d expected all 0",
                     RFwe, wb_finish, rf_rdaddr, rf_rd, grant_id);
        end
        for (int r = 4; r < 8; r++) begin
            rs1addr = 5'(r); rs2addr = 5'd0;
            #1;
            checks++;
            if (iss_stall !== 1'b0) begin
                errors++;
                $display("FAIL arst_busy[%0d]: iss_stall=%b expected 0", r, iss_stall);
            end
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_raw_stall();
        test_collision();
        test_x0();
        test_async_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
